mul_div_unit: RTL
=================

# mul_div_unit

Multi-cycle unsigned multiply/divide execution unit for the S1C88 core; sits beside `alu` in the execute stage and feeds the same writeback and flag-register path.
- MLT computes HL ← L × A, 8×8 → 16.
- DIV computes HL ÷ A → L = quotient, H = remainder, 16÷8.
- The decoder starts an operation and stalls on `busy`. The unit returns a 16-bit result and a 4-bit flag vector using the same bit order as `alu` (Z=0, C=1, V=2, S=3), so writeback needs no per-unit handling.

## Interface
- `RADIX_BITS`, default 1. Result bits retired per iteration; legal values are 1 and 2. Defines ITER = 8/RADIX_BITS.
- `clk`  in  1  core clock. All state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `op`  in  1  0 = MLT, 1 = DIV. Sampled with `start`.
- `a`  in  8  register A: multiplier or divisor.
- `hl`  in  16  register HL: L is the multiplicand; HL is the dividend.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse; `result`, `flags` and `div_zero` are valid in this cycle.
- `result`  out  16  new HL value.
- `flags`  out  4  {S,V,C,Z}.
- `div_zero`  out  1  set with `done` when DIV had A=0. Writeback is suppressed and the core raises the divide-by-zero exception.

## Operation
States:
- IDLE. Waits for `start`.
- CALC. Iterates; lasts ITER cycles.
- DONE. Asserts `done` for one cycle, then returns to IDLE.

Start, at the edge where `start`=1 and state is IDLE or DONE:
- Latch `op`, `a` and `hl`.
- Clear the iteration counter.
- Select the next state from the cases below.

MLT, shift-add:
- The 16-bit accumulator starts at 0.
- Each iteration adds (L << i) masked by the multiplier bit(s) and consumes RADIX_BITS bits of A, LSB first.
- Final flags: Z = (result == 0), S = result[15], C = 0, V = 0.

DIV, restoring:
- If A == 0: go straight to DONE with `div_zero`=1, `result`=hl, `flags`=0.
- Else if hl[15:8] ≥ A (quotient overflow): go straight to DONE with V=1, Z=S=C=0, `result`=hl (HL unchanged).
- Else go to CALC:
  - Partial remainder is 9 bits and starts at hl[15:8].
  - Each step shifts in the next dividend bit from hl[7:0], MSB first, then subtracts A when it fits. The quotient bit is 1 when the subtraction happens.
  - Final `result` = {remainder[7:0], quotient[7:0]}.
  - Z = (quotient == 0), S = quotient[7], C = 0, V = 0.

Outputs:
- `result`, `flags` and `div_zero` hold their values after DONE until the next accepted start. `div_zero` clears at the next start.
- During CALC, `result` and `flags` are not valid.

Boundary behaviour:
- `start` while `busy`=1 is ignored. No queueing, and in-flight operands are unaffected.
- `start` in the DONE cycle is accepted. Back-to-back operations have no bubble.
- `reset_n` low at any time, including mid-CALC, aborts the operation immediately. Nothing is written back.
- The counter wraps only through the IDLE/DONE transition and never overruns ITER.

## Timing
- Reset values: state = IDLE, `busy`=0, `done`=0, `result`=16'h0000, `flags`=4'h0, `div_zero`=0, internal accumulator and counter = 0.
- Normal path, with start accepted at edge k:
  - `busy`=1 during cycles k+1 … k+ITER.
  - `done`=1 during cycle k+ITER+1, with `busy`=0.
  - Latency is ITER+1 cycles: 9 for RADIX_BITS=1, 5 for RADIX_BITS=2.
- Fast paths (divide by zero, overflow): `done`=1 in cycle k+1 and `busy` never asserts.
- `done` is never high for two consecutive cycles unless a new start was accepted in the DONE cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MLT, a=0x34, hl=0x0012 → after 9 cycles, result 0x03A8, flags 4'b0000. MLT a=0xFF, hl=0x00FF → result 0xFE01, flags 4'b1000 (S).
- MLT a=0x00, hl=0xAB77 → result 0x0000, flags 4'b0001 (Z); the H input is ignored.
- DIV, a=0x56, hl=0x1234 → result 0x1036 (quotient 0x36, remainder 0x10), flags 0. DIV a=0x10, hl=0x0008 → result 0x0800, flags 4'b0001.
- DIV overflow, a=0x56, hl=0x5600 → `done` in cycle k+1, result 0x5600, flags 4'b0100 (V). DIV a=0x00 → `done` in k+1, `div_zero`=1, result = hl.
- Control, RADIX_BITS=1 and RADIX_BITS=2:
  - `start` pulsed again at k+3 with different operands → ignored; the original result is produced at k+9 (RADIX_BITS=1) or k+5 (RADIX_BITS=2).
  - `start` in the DONE cycle → second `done` exactly ITER+1 cycles later.
- `reset_n` asserted at k+4 of a DIV → `busy`, `done`, `result` and `flags` return to 0 asynchronously; a new MLT after release completes normally.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
// Decoder <-> multiply/divide unit handshake and data bundle.
//   start    : request, sampled only while the unit is not busy
//   op       : 0 = MLT (HL <- L * A), 1 = DIV (L <- HL / A, H <- HL % A)
//   a        : register A (multiplier or divisor)
//   hl       : register HL (L is the multiplicand, HL is the dividend)
//   busy     : high while iterating
//   done     : one-cycle pulse; result, flags and div_zero valid
//   result   : new HL value
//   flags    : {S,V,C,Z}, same bit order as the alu
//   div_zero : DIV attempted with A = 0
// Modports: master = decoder side, slave = execution unit side.
interface mul_div_unit_if;
  logic        start;
  logic        op;
  logic [7:0]  a;
  logic [15:0] hl;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        div_zero;

  modport master (
    output start, op, a, hl,
    input  busy, done, result, flags, div_zero
  );

  modport slave (
    input  start, op, a, hl,
    output busy, done, result, flags, div_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Multi-cycle unsigned 8x8 multiply (shift-add) and 16/8 restoring divide
// for the S1C88 execute stage. RADIX_BITS (1 or 2) result bits are retired
// per iteration, so an operation takes ITER = 8/RADIX_BITS iterations.
// Ports:
//   clk     : core clock, rising edge
//   reset_n : asynchronous active-low reset, aborts any operation
//   bus     : mul_div_unit_if.slave (start/op/a/hl in, busy/done/result/
//             flags/div_zero out, all outputs registered)
module mul_div_unit #(
  parameter int RADIX_BITS = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  mul_div_unit_if.slave  bus
);

  localparam int ITER = 8 / RADIX_BITS;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic        op_q;
  logic [7:0]  a_q;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [8:0]  rem;
  logic [7:0]  dq;
  logic [3:0]  cnt;

  logic        busy_q;
  logic        done_q;
  logic [15:0] result_q;
  logic [3:0]  flags_q;
  logic        div_zero_q;

  logic [15:0] nxt_acc;
  logic [15:0] nxt_mcand;
  logic [7:0]  nxt_mplier;
  logic [8:0]  nxt_rem;
  logic [7:0]  nxt_dq;
  logic        accept;
  logic        last_iter;

  assign accept    = bus.start && (state != CALC);
  assign last_iter = (cnt == 4'(ITER - 1));

  // One iteration of both datapaths; op_q picks which one is reported.
  // dq holds the not-yet-consumed dividend bits at the top and collects
  // quotient bits at the bottom, so after 8 steps it is the quotient.
  always_comb begin
    nxt_acc    = acc;
    nxt_mcand  = mcand;
    nxt_mplier = mplier;
    nxt_rem    = rem;
    nxt_dq     = dq;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (nxt_mplier[0]) begin
        nxt_acc = nxt_acc + nxt_mcand;
      end
      nxt_mcand  = nxt_mcand << 1;
      nxt_mplier = nxt_mplier >> 1;

      nxt_rem = {nxt_rem[7:0], nxt_dq[7]};
      nxt_dq  = {nxt_dq[6:0], 1'b0};
      if (nxt_rem >= {1'b0, a_q}) begin
        nxt_rem   = nxt_rem - {1'b0, a_q};
        nxt_dq[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_q       <= 1'b0;
      a_q        <= 8'h00;
      acc        <= 16'h0000;
      mcand      <= 16'h0000;
      mplier     <= 8'h00;
      rem        <= 9'h000;
      dq         <= 8'h00;
      cnt        <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 16'h0000;
      flags_q    <= 4'h0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      op_q       <= bus.op;
      a_q        <= bus.a;
      acc        <= 16'h0000;
      mcand      <= {8'h00, bus.hl[7:0]};
      mplier     <= bus.a;
      rem        <= {1'b0, bus.hl[15:8]};
      dq         <= bus.hl[7:0];
      cnt        <= 4'h0;
      div_zero_q <= 1'b0;
      if (bus.op && (bus.a == 8'h00)) begin
        state      <= DONE;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        div_zero_q <= 1'b1;
        result_q   <= bus.hl;
        flags_q    <= 4'b0000;
      end else if (bus.op && (bus.hl[15:8] >= bus.a)) begin
        // Quotient would not fit in 8 bits: HL is left unchanged.
        state    <= DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= bus.hl;
        flags_q  <= 4'b0100;
      end else begin
        state  <= CALC;
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end
    end else begin
      case (state)
        CALC: begin
          acc    <= nxt_acc;
          mcand  <= nxt_mcand;
          mplier <= nxt_mplier;
          rem    <= nxt_rem;
          dq     <= nxt_dq;
          cnt    <= cnt + 4'h1;
          if (last_iter) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (op_q) begin
              result_q <= {nxt_rem[7:0], nxt_dq};
              flags_q  <= {nxt_dq[7], 2'b00, (nxt_dq == 8'h00)};
            end else begin
              result_q <= nxt_acc;
              flags_q  <= {nxt_acc[15], 2'b00, (nxt_acc == 16'h0000)};
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.flags    = flags_q;
  assign bus.div_zero = div_zero_q;

endmodule
